univ_shift_seq: RTL and testbench

Parametrised universal shift register with a multi-cycle shift sequencer. It is the successor to the fixed 4-bit left/parallel shift register in Basic_CPU_Components. The block loads a W-bit word, then performs logical shifts, arithmetic shifts or rotates by a programmable amount at one bit per clock, with a Start/Busy/Done handshake. It serves as the shift unit of the basic CPU datapath, driven by the control unit.

---
 rtl/shreg_pkg.sv | 36 +++
 rtl/shreg_step.sv | 32 +++
 rtl/univ_shift_seq.sv | 111 +++++++++++
 tb/tb_univ_shift_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift sequencer: mode codes, FSM
// state encoding and the mode classifier.
// Optional feature macro: SHIFT_ROTATE_EN (enables ROL/ROR).
package shreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ASR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ROR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for modes that take Amt single-bit steps; everything else
  // (HOLD, LOAD, reserved, rotates when compiled out) finishes in one cycle.
  function automatic logic is_step_mode(input logic [2:0] mode);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ASR: r = 1'b1;
`ifdef SHIFT_ROTATE_EN
      MODE_ROL, MODE_ROR:           r = 1'b1;
`endif
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shreg_step.sv
// Single-step next-value function: one bit of shift/rotate per call.
// Optional feature macro: SHIFT_ROTATE_EN (rotate paths only exist when set).
module shreg_step
  import shreg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [2:0]   mode,
  input  logic         inl,
  input  logic         inr,
  output logic [W-1:0] nxt,
  output logic         carry_nxt
);

  // Non-step modes pass the word through; their carry output is unused.
  always_comb begin
    nxt       = cur;
    carry_nxt = 1'b0;
    case (mode)
      MODE_SHL: begin nxt = {cur[W-2:0], inl};      carry_nxt = cur[W-1]; end
      MODE_SHR: begin nxt = {inr, cur[W-1:1]};      carry_nxt = cur[0];   end
      MODE_ASR: begin nxt = {cur[W-1], cur[W-1:1]}; carry_nxt = cur[0];   end
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: begin nxt = {cur[W-2:0], cur[W-1]}; carry_nxt = cur[W-1]; end
      MODE_ROR: begin nxt = {cur[0], cur[W-1:1]};   carry_nxt = cur[0];   end
`endif
      default: begin nxt = cur; carry_nxt = 1'b0; end
    endcase
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register with multi-cycle sequencer (Start/Busy/Done).
// Optional feature macro: SHIFT_ROTATE_EN (ROL/ROR; otherwise they act as HOLD).
module univ_shift_seq
  import shreg_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = $clog2(W) + 1
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [W-1:0]  InA,
  input  logic          InR,
  input  logic          InL,
  input  logic [2:0]    Mode,
  input  logic [AW-1:0] Amt,
  input  logic          Start,
  output logic          Busy,
  output logic          Done,
  output logic [W-1:0]  Out,
  output logic          CarryOut
);

  state_t        state;
  logic [2:0]    mode_q;
  logic [AW-1:0] count;

  logic [2:0]    step_mode;
  logic [W-1:0]  step_out;
  logic          step_carry;

  // First step uses the live Mode (accepted this edge); later steps the latched one.
  always_comb begin
    step_mode = (state == ST_IDLE) ? Mode : mode_q;
  end

  shreg_step #(.W(W)) u_step (
    .cur       (Out),
    .mode      (step_mode),
    .inl       (InL),
    .inr       (InR),
    .nxt       (step_out),
    .carry_nxt (step_carry)
  );

  // Sequencer FSM, step counter and output registers.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_HOLD;
      count    <= '0;
      Out      <= '0;
      CarryOut <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          Busy <= 1'b0;
          if (Start) begin
            mode_q <= Mode;
            if (Mode == MODE_LOAD) begin
              Out      <= InA;
              CarryOut <= 1'b0;
              count    <= '0;
              state    <= ST_DONE;
              Done     <= 1'b1;
            end else if (is_step_mode(Mode) && (Amt != '0)) begin
              Out      <= step_out;
              CarryOut <= step_carry;
              count    <= Amt - AW'(1);
              if (Amt == AW'(1)) begin
                state <= ST_DONE;
                Done  <= 1'b1;
              end else begin
                state <= ST_RUN;
                Busy  <= 1'b1;
              end
            end else begin
              // HOLD, reserved, disabled rotate, or zero amount: no change.
              count <= '0;
              state <= ST_DONE;
              Done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          Out      <= step_out;
          CarryOut <= step_carry;
          count    <= count - AW'(1);
          if (count == AW'(1)) begin
            state <= ST_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        ST_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_seq.sv
// Directed table-driven bench for univ_shift_seq at W=8.
// Honours SHIFT_ROTATE_EN for rotate expectations.
module tb_univ_shift_seq;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RES = 1'b0;
  logic [W-1:0]  InA = '0;
  logic          InR = 1'b0;
  logic          InL = 1'b0;
  logic [2:0]    Mode = 3'b000;
  logic [AW-1:0] Amt = '0;
  logic          Start = 1'b0;
  logic          Busy, Done, CarryOut;
  logic [W-1:0]  Out;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_seq #(.W(W), .AW(AW)) dut (
    .CLK(CLK), .RES(RES), .InA(InA), .InR(InR), .InL(InL),
    .Mode(Mode), .Amt(Amt), .Start(Start),
    .Busy(Busy), .Done(Done), .Out(Out), .CarryOut(CarryOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [7:0]    ina;
    logic          inl;
    logic          inr;
    logic [7:0]    eout;
    logic          ecarry;
    int            elat;
    int            ebusy;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive Start for one edge, then count edges until Done (bounded).
  task automatic run_op(input vec_t v, input int idx);
    int lat, bcnt;
    @(negedge CLK);
    Mode = v.mode; Amt = v.amt; InA = v.ina; InL = v.inl; InR = v.inr;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 1; bcnt = 0;
    while (!Done && lat < 40) begin
      if (Busy) bcnt++;
      @(posedge CLK); #1;
      lat++;
    end
    if (Busy) bcnt++;
    chk("out", idx, 32'(Out), 32'(v.eout));
    chk("carry", idx, 32'(CarryOut), 32'(v.ecarry));
    chk("latency", idx, lat, v.elat);
    chk("busy_cycles", idx, bcnt, v.ebusy);
    @(posedge CLK); #1;
    chk("done_pulse", idx, 32'(Done), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] rot_out;
    logic       rot_c;

    vecs[0]  = '{3'b001, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 0};
    vecs[1]  = '{3'b010, 4'd3,  8'h00, 1'b1, 1'b0, 8'h2F, 1'b1, 3, 2};
    vecs[2]  = '{3'b001, 4'd0,  8'h85, 1'b0, 1'b0, 8'h85, 1'b0, 1, 0};
    vecs[3]  = '{3'b100, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE1, 1'b0, 2, 1};
    vecs[4]  = '{3'b011, 4'd9,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 9, 8};
    vecs[5]  = '{3'b001, 4'd1,  8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1, 0};
`ifdef SHIFT_ROTATE_EN
    vecs[6]  = '{3'b101, 4'd1,  8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1, 0};
    vecs[7]  = '{3'b110, 4'd8,  8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 8, 7};
    rot_out = 8'h03; rot_c = 1'b0;
`else
    vecs[6]  = '{3'b101, 4'd1,  8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1, 0};
    vecs[7]  = '{3'b110, 4'd8,  8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1, 0};
    rot_out = 8'h81; rot_c = 1'b0;
`endif
    vecs[8]  = '{3'b000, 4'd5,  8'hFF, 1'b1, 1'b1, rot_out, rot_c, 1, 0};
    vecs[9]  = '{3'b001, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1, 0};
    vecs[10] = '{3'b010, 4'd1,  8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1, 0};
    vecs[11] = '{3'b010, 4'd0,  8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 1, 0};
    vecs[12] = '{3'b111, 4'd3,  8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1, 0};
    vecs[13] = '{3'b001, 4'd0,  8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1, 0};
    vecs[14] = '{3'b100, 4'd10, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 10, 9};
    vecs[15] = '{3'b001, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1, 0};
    vecs[16] = '{3'b011, 4'd2,  8'h00, 1'b0, 1'b1, 8'hCF, 1'b0, 2, 1};
    vecs[17] = '{3'b010, 4'd8,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8, 7};

    // Reset state
    #1;
    chk("rst_out", 0, 32'(Out), 32'd0);
    chk("rst_carry", 0, 32'(CarryOut), 32'd0);
    chk("rst_busy", 0, 32'(Busy), 32'd0);
    chk("rst_done", 0, 32'(Done), 32'd0);
    @(negedge CLK);
    RES = 1'b1;

    for (int i = 0; i < 18; i++) run_op(vecs[i], i);

    // Start / Mode / Amt / InA changes during RUN and DONE are ignored.
    run_op('{3'b001, 4'd0, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1, 0}, 100);
    @(negedge CLK);
    Mode = 3'b010; Amt = 4'd3; InL = 1'b0; Start = 1'b1;
    @(posedge CLK); #1;
    Mode = 3'b001; Amt = 4'd1; InA = 8'hFF;   // Start stays high
    lat = 1;
    while (!Done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("midrun_out", 101, 32'(Out), 32'h78);
    chk("midrun_carry", 101, 32'(CarryOut), 32'd0);
    chk("midrun_latency", 101, lat, 3);
    @(posedge CLK); #1;                         // DONE edge with Start high
    chk("done_ign_out", 102, 32'(Out), 32'h78);
    chk("done_ign_busy", 102, 32'(Busy), 32'd0);
    chk("done_ign_done", 102, 32'(Done), 32'd0);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of RUN.
    run_op('{3'b001, 4'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1, 0}, 103);
    @(negedge CLK);
    Mode = 3'b011; Amt = 4'd5; InR = 1'b0; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #3;
    chk("pre_rst_busy", 104, 32'(Busy), 32'd1);
    chk("pre_rst_carry", 104, 32'(CarryOut), 32'd1);
    RES = 1'b0;
    #1;
    chk("rst_mid_out", 104, 32'(Out), 32'd0);
    chk("rst_mid_busy", 104, 32'(Busy), 32'd0);
    chk("rst_mid_done", 104, 32'(Done), 32'd0);
    chk("rst_mid_carry", 104, 32'(CarryOut), 32'd0);
    @(negedge CLK);
    RES = 1'b1;
    Mode = 3'b001; InA = 8'h5A; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    chk("post_rst_out", 105, 32'(Out), 32'h5A);
    chk("post_rst_done", 105, 32'(Done), 32'd1);
    @(posedge CLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
